// File: rtl/databus.sv
// Shared CP0 definitions: register numbers, exception codes, SR/Cause layouts
// and the fixed fetch addresses used by the core.
package databus;

  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] RESET_PC   = 32'h0000_3000;

  typedef enum logic [4:0] {
    Int  = 5'd0,
    AdEL = 5'd4,
    AdES = 5'd5,
    RI   = 5'd10,
    Ov   = 5'd12
  } EXCCODE;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [5:0]  im;
    logic [7:0]  rsvd_lo;
    logic        exl;
    logic        ie;
  } sr_t;

  typedef struct packed {
    logic        bd;
    logic [14:0] rsvd_hi;
    logic [5:0]  ip;
    logic [2:0]  rsvd_mid;
    logic [4:0]  exccode;
    logic [1:0]  rsvd_lo;
  } cause_t;

endpackage

// File: rtl/cp0_req_gen.sv
// Exception/interrupt request decode from live inputs and current SR bits.
// Purely combinational; no state and no backpressure.
module cp0_req_gen
  import databus::*;
(
  input  logic [5:0] im_i,
  input  logic       ie_i,
  input  logic       exl_i,
  input  logic [5:0] hwint_i,
  input  logic [4:0] exccode_i,
  output logic       int_req_o,
  output logic       exc_req_o,
  output logic       req_o,
  output logic [4:0] rec_exccode_o
);

  assign int_req_o = (|(hwint_i & im_i)) & ie_i & ~exl_i;
  assign exc_req_o = (exccode_i != 5'd0) & ~exl_i;
  assign req_o     = int_req_o | exc_req_o;

  // An interrupt outranks a synchronous exception in the same cycle.
  assign rec_exccode_o = int_req_o ? Int : exccode_i;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId state, mtc0/mfc0/eret, flush request.
// Req/EPC_out/rdata are same-cycle combinational; state updates on the next edge.
module cp0_exc_ctrl
  import databus::*;
#(
  parameter logic [31:0] PRID_VAL   = 32'h2005_0704,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic [31:0] PC_in,
  input  logic        BD_in,
  input  logic [4:0]  ExcCode_in,
  input  logic [5:0]  HWInt,
  input  logic        eret,
  output logic        Req,
  output logic [31:0] EPC_out
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic        req_raw;
  logic [4:0]  rec_exccode;
  logic [31:0] trap_pc;
  logic        epc_wr;
  sr_t         sr_rd;
  cause_t      cause_rd;

  cp0_req_gen u_req_gen (
    .im_i          (im_q),
    .ie_i          (ie_q),
    .exl_i         (exl_q),
    .hwint_i       (HWInt),
    .exccode_i     (ExcCode_in),
    .int_req_o     (int_req),
    .exc_req_o     (exc_req),
    .req_o         (req_raw),
    .rec_exccode_o (rec_exccode)
  );

  assign Req     = req_raw & reset;
  assign trap_pc = (BD_in ? (PC_in - 32'd4) : PC_in) & 32'hFFFF_FFFC;
  assign epc_wr  = we && (addr == CP0_EPC);

  // Forward a same-cycle mtc0 EPC so a back-to-back eret sees the new target.
  always_comb begin
    EPC_out = epc_q;
    if (!reset) begin
      EPC_out = 32'd0;
    end else if (Req) begin
      EPC_out = HANDLER_PC;
    end else if (epc_wr) begin
      EPC_out = wdata & 32'hFFFF_FFFC;
    end
  end

  always_comb begin
    sr_rd     = '0;
    sr_rd.im  = im_q;
    sr_rd.exl = exl_q;
    sr_rd.ie  = ie_q;

    cause_rd         = '0;
    cause_rd.bd      = bd_q;
    cause_rd.ip      = ip_q;
    cause_rd.exccode = exccode_q;

    case (addr)
      CP0_SR:    rdata = sr_rd;
      CP0_CAUSE: rdata = cause_rd;
      CP0_EPC:   rdata = epc_q;
      CP0_PRID:  rdata = PRID_VAL;
      default:   rdata = 32'd0;
    endcase
  end

  always_comb begin
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;
    ip_d      = HWInt;

    if (Req) begin
      exl_d     = 1'b1;
      bd_d      = BD_in;
      exccode_d = rec_exccode;
      epc_d     = trap_pc;
    end else begin
      if (we && (addr == CP0_SR)) begin
        im_d  = wdata[15:10];
        exl_d = wdata[1];
        ie_d  = wdata[0];
      end
      if (epc_wr) begin
        epc_d = wdata & 32'hFFFF_FFFC;
      end
      // eret clears EXL even when an mtc0 SR in the same cycle tries to set it.
      if (eret) begin
        exl_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_q      <= '0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ip_q      <= '0;
      exccode_q <= '0;
      epc_q     <= '0;
    end else begin
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ip_q      <= ip_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

endmodule

// File: doc/cp0_exc_ctrl.md
# cp0_exc_ctrl

Coprocessor-0 exception controller for the five-stage MIPS core. It is the request end of the pipeline flush interface: it observes the instruction committing in MEM, decides whether an exception or interrupt is taken, and drives `Req`, which flushes the pipeline registers and redirects fetch to the handler. It holds SR, Cause, EPC and PRId, and serves `mtc0`, `mfc0` and `eret`.

## Interface
Parameters:
- `PRID_VAL`, default 32'h2005_0704: read-only PRId value.
- `HANDLER_PC`, default 32'h0000_4180: exception entry address, exported on `EPC_out` while `Req` is high.

Ports:
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `we`  in  1  `mtc0` write enable, MEM stage
- `addr`  in  5  CP0 register number for read and write
- `wdata`  in  32  `mtc0` data
- `rdata`  out  32  `mfc0` data, combinational
- `PC_in`  in  32  PC of the MEM-stage instruction; valid even for bubbles
- `BD_in`  in  1  MEM-stage instruction is in a branch delay slot
- `ExcCode_in`  in  5  exception code from MEM; 0 means none
- `HWInt`  in  6  external interrupt lines, synchronous to `clk`
- `eret`  in  1  `eret` is in MEM
- `Req`  out  1  take an exception this cycle (flush and redirect)
- `EPC_out`  out  32  redirect target: `HANDLER_PC` when `Req`, otherwise the forwarded EPC

## Operation
Registers:
- **SR (12):** IM[15:10], EXL[1], IE[0]. All other bits read 0.
- **Cause (13):** BD[31], IP[15:10], ExcCode[6:2]. Software cannot write Cause.
- **EPC (14):** 32 bits; bits [1:0] are forced to 0 on every write.
- **PRId (15):** returns `PRID_VAL`.
- Any other `addr` reads 0. Writes to it are ignored.

Request generation (combinational):
- `IntReq` = |(HWInt & SR.IM) & SR.IE & !SR.EXL
- `ExcReq` = (ExcCode_in != 0) & !SR.EXL
- `Req` = `IntReq` | `ExcReq`, forced to 0 while `reset` is low.
- When both are active, the interrupt wins and ExcCode records 0.

At each clock edge, in priority order:
1. **`Req`:** EXL←1, Cause.BD←`BD_in`, Cause.ExcCode←(`IntReq` ? 0 : `ExcCode_in`), EPC←(`BD_in` ? `PC_in`−4 : `PC_in`) & ~3. Any simultaneous `we` or `eret` is discarded.
2. **`eret`:** EXL←0. A simultaneous `we` still applies, except that its EXL bit is overridden by 0.
3. **`we`:** updates the addressed writable register.

Every cycle, independent of the above: Cause.IP←`HWInt`.

Forwarding and arithmetic:
- `EPC_out` = `Req` ? `HANDLER_PC` : (`we` && `addr`==14 ? `wdata` & ~3 : EPC). This lets an `eret` directly after `mtc0 EPC` use the new value.
- `PC_in`−4 wraps modulo 2^32.

## Timing
- Reset (async, `reset`=0): SR=0, Cause=0, EPC=0; `Req`=0; `EPC_out`=0; `rdata` reflects the reset values.
- `Req` and `EPC_out` are same-cycle combinational. The consuming pipeline registers and PC register sample them on the same rising edge.
- CP0 state updates at that edge, so `Req` drops the next cycle because EXL=1.
- `rdata` gives the pre-edge register value. There is no bypass of a same-cycle `we` into `rdata`.
- Cause.IP lags `HWInt` by one cycle. `IntReq` uses the live `HWInt`.
- When reset deasserts, operation starts normally on the next edge.
- If reset asserts in the same cycle as `Req`, reset wins and no state is captured.

## Structure
- Add to package `databus`:
  - Register indices `CP0_SR`, `CP0_CAUSE`, `CP0_EPC`, `CP0_PRID`
  - Enum `EXCCODE` (Int=0, AdEL=4, AdES=5, RI=10, Ov=12)
  - Packed structs for the SR and Cause layouts
  - Constants `HANDLER_PC`=32'h4180 and `RESET_PC`=32'h3000
- Sub-module `cp0_req_gen`: purely combinational. It computes `IntReq`, `ExcReq`, `Req` and the recorded ExcCode. The top level holds all state.

## Test plan
- **Interrupt taken:** reset; `mtc0 SR`=32'h0000_0401; raise `HWInt`=6'b000001 with `PC_in`=32'h3010, `BD_in`=0 → `Req`=1 that cycle. Next cycle: EPC=32'h3010, Cause=32'h0000_0400 (IP[10] set, ExcCode=0), SR.EXL=1, `Req`=0.
- **Exception in delay slot:** `ExcCode_in`=12 (Ov), `BD_in`=1, `PC_in`=32'h3024 → Cause.BD=1, ExcCode=12, EPC=32'h3020.
- **Masking:** IE=1, IM=0, `HWInt`=6'h3F → `Req`=0. With EXL=1 and `ExcCode_in`=10 → `Req`=0 and registers unchanged.
- **Simultaneous events:** `we` to EPC with 32'h5000 in the same cycle as `ExcCode_in`=4 at `PC_in`=32'h3100 → EPC=32'h3100, and the write is dropped.
- **eret path:** `mtc0 EPC`=32'h3047 with `eret` in the same cycle → `EPC_out`=32'h3044, then EXL=0.
- **Reset mid-exception:** assert `reset`=0 asynchronously while `Req`=1 → `Req`=0 immediately; SR, Cause and EPC read 0; PRId reads `PRID_VAL`.
